// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//   Fetch stage. Holds the fetch PC, keeps at most one instruction-memory
//   request outstanding, buffers returned words in a small FIFO and presents
//   the FIFO head to decode through a valid/ready handshake. A branch/jump
//   redirect flushes the buffer. If a request is still in flight when the
//   redirect arrives, the stage waits for that request to complete and drops
//   its data before it fetches from the new address.
//
// Ports
//   clk          in   1   system clock, rising edge
//   rst_n        in   1   asynchronous active-low reset
//   imem_req     out  1   memory request, held until imem_ack
//   imem_addr    out  32  word-aligned fetch address, stable while imem_req=1
//   imem_ack     in   1   memory completion, ignored while imem_req=0
//   imem_rdata   in   32  instruction word, valid with imem_ack
//   redirect     in   1   branch/jump taken (single-cycle pulse)
//   redirect_pc  in   32  new fetch address, bits [1:0] ignored
//   dec_valid    out  1   buffer head valid
//   dec_ready    in   1   decode accepts head
//   dec_instr    out  32  head instruction, 0 when dec_valid=0
//   dec_pc       out  32  head instruction address, 0 when dec_valid=0
//   dec_imm16    out  16  dec_instr[15:0], raw immediate for the sign extender
// -----------------------------------------------------------------------------
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  output logic [15:0] dec_imm16
);

  localparam int unsigned   CW         = $clog2(BUF_DEPTH + 1);
  localparam int unsigned   PW         = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C    = CW'(BUF_DEPTH);
  localparam logic [PW-1:0] LAST_PTR_C = PW'(BUF_DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DISCARD = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   pending_pc_q, pending_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   instr_buf_q [BUF_DEPTH];
  logic [31:0]   pc_buf_q    [BUF_DEPTH];

  logic          ack_s;
  logic          pop_s;
  logic          push_s;
  logic          space_s;
  logic [31:0]   redir_pc_s;
  logic          unused_redirect_lsb_s;

  // Circular pointer advance; also correct for depths that are not powers of two.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    if (ptr == LAST_PTR_C) begin
      next_ptr = '0;
    end else begin
      next_ptr = ptr + PW'(1);
    end
  endfunction

  assign redir_pc_s            = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsb_s = ^redirect_pc[1:0];

  // A completion only counts while a request is actually on the bus.
  assign ack_s  = imem_ack & imem_req;
  assign pop_s  = dec_valid & dec_ready;
  // Data is only kept for a live WAIT request that is not being redirected away.
  assign push_s = (state_q == ST_WAIT) & ack_s & ~redirect;

  // Buffer occupancy and pointers; a redirect empties the buffer and beats push/pop.
  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (redirect) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      count_d = count_q + {{(CW-1){1'b0}}, push_s} - {{(CW-1){1'b0}}, pop_s};
      if (pop_s) begin
        rd_ptr_d = next_ptr(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      if (push_s) begin
        wr_ptr_d = next_ptr(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
    end
  end

  // Space looks at the occupancy after this edge, so a full buffer being popped keeps fetching.
  assign space_s = (count_d < DEPTH_C);

  // Fetch FSM next-state and fetch/pending PC update.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    pending_pc_d = pending_pc_q;
    case (state_q)
      ST_IDLE: begin
        if (redirect) begin
          fetch_pc_d = redir_pc_s;
          state_d    = ST_WAIT;
        end else if (space_s) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (redirect && ack_s) begin
          // Old request retires this edge, so the new address can go out at once.
          fetch_pc_d = redir_pc_s;
          state_d    = ST_WAIT;
        end else if (redirect) begin
          // imem_addr must stay stable until the old request completes.
          pending_pc_d = redir_pc_s;
          state_d      = ST_DISCARD;
        end else if (ack_s) begin
          fetch_pc_d = fetch_pc_q + 32'd4;
          if (space_s) begin
            state_d = ST_WAIT;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DISCARD: begin
        if (ack_s) begin
          // The newest redirect wins if one arrives together with the completion.
          if (redirect) begin
            fetch_pc_d = redir_pc_s;
          end else begin
            fetch_pc_d = pending_pc_q;
          end
          state_d = ST_WAIT;
        end else if (redirect) begin
          pending_pc_d = redir_pc_s;
          state_d      = ST_DISCARD;
        end else begin
          state_d = ST_DISCARD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, PC and buffer-control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      fetch_pc_q   <= RESET_PC;
      pending_pc_q <= RESET_PC;
      count_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      pending_pc_q <= pending_pc_d;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
    end
  end

  // Buffer storage: one {pc, instruction} pair per entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        instr_buf_q[i] <= 32'h0000_0000;
        pc_buf_q[i]    <= 32'h0000_0000;
      end
    end else if (push_s) begin
      instr_buf_q[wr_ptr_q] <= imem_rdata;
      pc_buf_q[wr_ptr_q]    <= fetch_pc_q;
    end
  end

  assign imem_req  = (state_q != ST_IDLE);
  assign imem_addr = fetch_pc_q;
  assign dec_valid = (count_q != '0);
  assign dec_instr = dec_valid ? instr_buf_q[rd_ptr_q] : 32'h0000_0000;
  assign dec_pc    = dec_valid ? pc_buf_q[rd_ptr_q]    : 32'h0000_0000;
  assign dec_imm16 = dec_instr[15:0];

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
//   Directed bench for instruction_fetch. The main instance uses RESET_PC=0
//   and BUF_DEPTH=2. A second instance uses RESET_PC=32'hFFFFFFFC to cover
//   address wrap. Inputs change 1 ns after a rising edge, and outputs are
//   read at that same point.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic [15:0] dec_imm16;

  logic        w_imem_req;
  logic [31:0] w_imem_addr;
  logic        w_imem_ack;
  logic        w_dec_valid;
  logic [31:0] w_dec_instr;
  logic [31:0] w_dec_pc;
  logic [15:0] w_dec_imm16;

  int n_cmp;
  int n_bad;

  instruction_fetch #(
    .RESET_PC  (32'h0000_0000),
    .BUF_DEPTH (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .dec_valid   (dec_valid),
    .dec_ready   (dec_ready),
    .dec_instr   (dec_instr),
    .dec_pc      (dec_pc),
    .dec_imm16   (dec_imm16)
  );

  instruction_fetch #(
    .RESET_PC  (32'hFFFF_FFFC),
    .BUF_DEPTH (2)
  ) dut_wrap (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (w_imem_req),
    .imem_addr   (w_imem_addr),
    .imem_ack    (w_imem_ack),
    .imem_rdata  (32'hABCD_0001),
    .redirect    (1'b0),
    .redirect_pc (32'h0000_0000),
    .dec_valid   (w_dec_valid),
    .dec_ready   (1'b1),
    .dec_instr   (w_dec_instr),
    .dec_pc      (w_dec_pc),
    .dec_imm16   (w_dec_imm16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply reset across two edges and release it between edges.
  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Directed stimulus sequence.
  initial begin
    n_cmp       = 0;
    n_bad       = 0;
    rst_n       = 1'b0;
    imem_ack    = 1'b0;
    imem_rdata  = 32'h0000_0000;
    redirect    = 1'b0;
    redirect_pc = 32'h0000_0000;
    dec_ready   = 1'b0;
    w_imem_ack  = 1'b0;

    // Reset values
    tick();
    tick();
    check_val("rst_req",   {31'd0, imem_req},  32'd0);
    check_val("rst_addr",  imem_addr,          32'h0000_0000);
    check_val("rst_valid", {31'd0, dec_valid}, 32'd0);
    check_val("rst_instr", dec_instr,          32'h0000_0000);
    check_val("rst_pc",    dec_pc,             32'h0000_0000);
    check_val("rst_imm",   {16'd0, dec_imm16}, 32'h0000_0000);
    check_val("w_rst_addr", w_imem_addr,       32'hFFFF_FFFC);
    rst_n = 1'b1;
    check_val("rel_req_low", {31'd0, imem_req}, 32'd0);
    tick();
    check_val("first_req",  {31'd0, imem_req}, 32'd1);
    check_val("first_addr", imem_addr,          32'h0000_0000);
    check_val("w_first_addr", w_imem_addr,      32'hFFFF_FFFC);

    // Wrap instance: one ack at FFFFFFFC, then the address wraps to 0
    w_imem_ack = 1'b1;
    // Sequential fetch
    dec_ready  = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'h2008_FFFF;
    tick();
    w_imem_ack = 1'b0;
    check_val("w_wrap_addr", w_imem_addr, 32'h0000_0000);
    check_val("w_wrap_pc",   w_dec_pc,    32'hFFFF_FFFC);
    check_val("seq_valid0", {31'd0, dec_valid}, 32'd1);
    check_val("seq_instr0", dec_instr,          32'h2008_FFFF);
    check_val("seq_pc0",    dec_pc,             32'h0000_0000);
    check_val("seq_imm0",   {16'd0, dec_imm16}, 32'h0000_FFFF);
    check_val("seq_addr4",  imem_addr,          32'h0000_0004);
    imem_rdata = 32'h2009_0004;
    tick();
    check_val("seq_pc1",   dec_pc,             32'h0000_0004);
    check_val("seq_imm1",  {16'd0, dec_imm16}, 32'h0000_0004);
    check_val("seq_addr8", imem_addr,          32'h0000_0008);
    check_val("seq_req",   {31'd0, imem_req},  32'd1);
    imem_ack = 1'b0;
    tick();
    check_val("seq_drain_valid", {31'd0, dec_valid}, 32'd0);
    check_val("seq_drain_instr", dec_instr,          32'h0000_0000);

    // Backpressure from a fresh reset
    do_reset();
    tick();
    dec_ready  = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'h2008_FFFF;
    tick();
    imem_rdata = 32'h2009_0004;
    tick();
    check_val("bp_req_low", {31'd0, imem_req}, 32'd0);
    check_val("bp_instr",   dec_instr,         32'h2008_FFFF);
    check_val("bp_pc",      dec_pc,            32'h0000_0000);
    check_val("bp_addr",    imem_addr,         32'h0000_0008);
    imem_rdata = 32'h7777_7777;
    tick();
    check_val("bp_hold_req",   {31'd0, imem_req}, 32'd0);
    check_val("bp_hold_instr", dec_instr,         32'h2008_FFFF);
    dec_ready = 1'b1;
    imem_ack  = 1'b0;
    tick();
    check_val("bp_resume_req",  {31'd0, imem_req}, 32'd1);
    check_val("bp_resume_addr", imem_addr,         32'h0000_0008);
    check_val("bp_second_pc",   dec_pc,            32'h0000_0004);
    check_val("bp_second_ins",  dec_instr,         32'h2009_0004);
    imem_ack   = 1'b1;
    imem_rdata = 32'h3333_0008;
    tick();
    check_val("bp_third_pc",  dec_pc,    32'h0000_0008);
    check_val("bp_third_ins", dec_instr, 32'h3333_0008);
    check_val("bp_addr_c",    imem_addr, 32'h0000_000C);
    imem_ack = 1'b0;
    tick();
    check_val("bp_empty", {31'd0, dec_valid}, 32'd0);

    // Redirect while the request at 0xC is outstanding
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0100;
    tick();
    redirect = 1'b0;
    check_val("disc_addr_hold", imem_addr,         32'h0000_000C);
    check_val("disc_req",       {31'd0, imem_req}, 32'd1);
    tick();
    check_val("disc_addr_hold2", imem_addr, 32'h0000_000C);
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    check_val("disc_dropped", {31'd0, dec_valid}, 32'd0);
    check_val("disc_newaddr", imem_addr,          32'h0000_0100);
    imem_rdata = 32'h1111_0100;
    tick();
    imem_ack = 1'b0;
    check_val("redir_pc",    dec_pc,    32'h0000_0100);
    check_val("redir_instr", dec_instr, 32'h1111_0100);
    check_val("redir_addr",  imem_addr, 32'h0000_0104);

    // Same-cycle redirect, ack and pop with one buffered entry; misaligned target
    imem_ack    = 1'b1;
    imem_rdata  = 32'h5555_5555;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0203;
    tick();
    imem_ack = 1'b0;
    redirect = 1'b0;
    check_val("same_valid", {31'd0, dec_valid}, 32'd0);
    check_val("same_pc",    dec_pc,             32'h0000_0000);
    check_val("same_req",   {31'd0, imem_req},  32'd1);
    check_val("same_align", imem_addr,          32'h0000_0200);

    // Two redirects while discarding: the later one wins
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0300;
    tick();
    redirect_pc = 32'h0000_0400;
    tick();
    redirect = 1'b0;
    check_val("disc2_hold", imem_addr, 32'h0000_0200);
    imem_ack   = 1'b1;
    imem_rdata = 32'h9999_9999;
    tick();
    check_val("disc2_addr",  imem_addr,          32'h0000_0400);
    check_val("disc2_empty", {31'd0, dec_valid}, 32'd0);

    // Asynchronous reset mid-WAIT with a buffered entry
    dec_ready  = 1'b0;
    imem_rdata = 32'h4444_0400;
    tick();
    imem_ack = 1'b0;
    check_val("pre_rst_valid", {31'd0, dec_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("arst_req",   {31'd0, imem_req},  32'd0);
    check_val("arst_valid", {31'd0, dec_valid}, 32'd0);
    check_val("arst_addr",  imem_addr,          32'h0000_0000);
    tick();
    rst_n = 1'b1;
    tick();
    check_val("post_rst_req",  {31'd0, imem_req}, 32'd1);
    check_val("post_rst_addr", imem_addr,         32'h0000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Fetch stage of the processor datapath, directly upstream of the immediate sign extender. Keeps the fetch PC and issues single-outstanding requests to instruction memory. Buffers returned words in a small FIFO and presents them to decode with a valid/ready handshake. Drives the raw 16-bit immediate field consumed by the sign-extension stage, and handles branch/jump redirects by flushing the buffer.

Parameters:
RESET_PC, 32'h00000000, fetch address after reset; bits [1:0] must be 0.
BUF_DEPTH, 2, instruction buffer entries; legal values 2..8.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
imem_req  output  1  memory request; held until imem_ack.
imem_addr  output  32  word-aligned fetch address; stable while imem_req=1.
imem_ack  input  1  memory completion, sampled at clk edge when imem_req=1; ignored otherwise.
imem_rdata  input  32  instruction word, valid with imem_ack.
redirect  input  1  branch/jump taken; single-cycle pulse.
redirect_pc  input  32  new fetch address; bits [1:0] forced to 0 internally.
dec_valid  output  1  buffer head valid.
dec_ready  input  1  decode accepts head.
dec_instr  output  32  head instruction; 0 when dec_valid=0.
dec_pc  output  32  head instruction address; 0 when dec_valid=0.
dec_imm16  output  16  dec_instr[15:0], feeds the sign extender.

Behaviour:
- Clock and reset: one clock (clk). rst_n is asynchronous and active-low.
- Reset (asynchronous, immediate, no clock edge needed):
  - state=IDLE, buffer empty, fetch_pc=RESET_PC.
  - imem_req=0, imem_addr=RESET_PC, dec_valid=0, dec_instr=0, dec_pc=0, dec_imm16=0.
  - An in-flight memory transaction is abandoned; memory must tolerate this.
- FSM states:
  - IDLE: no request.
  - WAIT: request for fetch_pc outstanding.
  - DISCARD: old request still outstanding after a redirect; its data is dropped.
- Outputs: imem_req=1 in WAIT and DISCARD. imem_addr=fetch_pc, which is not updated while a request is outstanding.
- Space rule: space = (count after this edge's push/pop) < BUF_DEPTH.
- IDLE -> WAIT when space. The first imem_req rises on the first edge after rst_n deasserts.
- WAIT, imem_ack=1, no redirect:
  - Push {fetch_pc, imem_rdata}; fetch_pc += 4.
  - Stay in WAIT if space, else go to IDLE.
  - Back-to-back acks give 1 instr/cycle with imem_req held high continuously.
- WAIT, redirect=1 and imem_ack=1 same cycle: data dropped, fetch_pc=redirect_pc, stay in WAIT.
- WAIT, redirect=1, no ack: go to DISCARD; pending_pc=redirect_pc. imem_addr keeps the old address.
- DISCARD:
  - A further redirect overwrites pending_pc.
  - On imem_ack: data dropped, fetch_pc=pending_pc, go to WAIT.
- IDLE, redirect: fetch_pc=redirect_pc, go to WAIT.
- Redirect in any state flushes the buffer (count=0) at that edge.
  - Priority: redirect > push/pop.
  - A pop in the redirect cycle is still a handshake: decode consumed it.
- Buffer behaviour:
  - FIFO order.
  - dec_valid = (count != 0); pop when dec_valid & dec_ready.
  - Simultaneous push and pop when full is legal; count unchanged.
  - Push never occurs when count=BUF_DEPTH, guaranteed by the space rule.
- Latency: ack at edge N -> dec_valid=1 with that instruction after edge N (visible in cycle N+1).
- Head outputs stay stable while dec_valid=1 and dec_ready=0.
- fetch_pc wraps modulo 2^32: 32'hFFFFFFFC + 4 = 32'h00000000.

Test Plan:
- Sequential fetch: reset, then imem_ack every cycle with rdata 32'h2008FFFF, 32'h20090004, ...; dec_ready=1 -> imem_addr 0,4,8...; dec_pc 0,4 in order; dec_imm16 = FFFF then 0004.
- Backpressure: dec_ready=0, ack every cycle -> after 2 pushes (BUF_DEPTH=2) imem_req=0 and head stays 32'h2008FFFF/pc 0. Raise dec_ready -> fetch resumes at addr 8 with no loss or duplication.
- Redirect during outstanding request: imem_addr=8, ack withheld; pulse redirect_pc=32'h00000100 -> imem_addr stays 8 until ack. Then that data is not presented, next imem_addr=0x100, first dec_pc=0x100.
- Same-cycle redirect + ack + pop: buffer holds 1 entry, dec_ready=1 -> buffer empty next cycle, dec_valid=0, imem_addr=redirect_pc with req still high.
- Wrap and alignment: RESET_PC=32'hFFFFFFFC -> addresses FFFFFFFC then 00000000. redirect_pc=32'h00000203 -> imem_addr=32'h00000200.
- Asynchronous reset mid-WAIT: drop rst_n between edges -> imem_req=0 and dec_valid=0 immediately. After release, the first request is at RESET_PC.
